// File: rtl/cb_filter_arb.sv
// Admission controller in front of a cb_filter used as an item hazard tracker.
// Round-robin picks one insert requester per cycle, admits it on a filter miss, forwards releases, sequences drain/clear.
module cb_filter_arb #(
    parameter int NumReq       = 4,
    parameter int InpWidth     = 32,
    parameter int HashWidth    = 4,
    parameter int MaxInFlight  = 12,
    parameter int DrainTimeout = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumReq-1:0]            req_valid_i,
    input  logic [NumReq*InpWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic                         rel_valid_i,
    input  logic [InpWidth-1:0]          rel_data_i,
    output logic                         rel_ready_o,
    output logic [InpWidth-1:0]          look_data_o,
    input  logic                         look_valid_i,
    output logic [InpWidth-1:0]          incr_data_o,
    output logic                         incr_valid_o,
    output logic [InpWidth-1:0]          decr_data_o,
    output logic                         decr_valid_o,
    input  logic [HashWidth-1:0]         filter_usage_i,
    input  logic                         filter_full_i,
    input  logic                         filter_empty_i,
    input  logic                         filter_error_i,
    output logic                         filter_clear_o,
    input  logic                         clear_req_i,
    output logic                         clear_busy_o,
    output logic                         clear_done_o,
    output logic                         error_o,
    output logic [15:0]                  stall_cnt_o
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = $clog2(DrainTimeout + 1);
    localparam logic [HashWidth-1:0] MaxIf   = HashWidth'(MaxInFlight);
    localparam logic [CntW-1:0]      DrainLd = CntW'(DrainTimeout - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       ptr_q, ptr_d;
    logic [15:0]           stall_q, stall_d;
    logic                  error_q, error_d;
    logic                  err_to_q, err_to_d;
    logic [CntW-1:0]       drain_cnt_q, drain_cnt_d;
    logic [InpWidth-1:0]   look_data_q, look_data_d;

    logic                  any_valid;
    logic [PtrW-1:0]       win;
    logic [PtrW-1:0]       win_next;
    logic [InpWidth-1:0]   win_data;

    logic [NumReq-1:0]     req_ready;
    logic                  incr_valid;
    logic                  rel_ready;
    logic                  filter_clear;
    logic                  clear_done;
    logic                  clear_busy;

    // Round-robin search starting at the pointer, wrapping at NumReq.
    always_comb begin
        int idx;
        any_valid = 1'b0;
        win       = '0;
        idx       = 0;
        for (int i = 0; i < NumReq; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!any_valid && req_valid_i[idx]) begin
                any_valid = 1'b1;
                win       = PtrW'(idx);
            end
        end
    end

    assign win_data = req_data_i[int'(win)*InpWidth +: InpWidth];
    assign win_next = (int'(win) == NumReq - 1) ? '0 : win + PtrW'(1);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        stall_d      = stall_q;
        error_d      = error_q;
        err_to_d     = err_to_q;
        drain_cnt_d  = drain_cnt_q;
        look_data_d  = any_valid ? win_data : look_data_q;
        req_ready    = '0;
        incr_valid   = 1'b0;
        rel_ready    = 1'b0;
        filter_clear = 1'b0;
        clear_done   = 1'b0;
        clear_busy   = 1'b0;

        case (state_q)
            ST_RUN: begin
                rel_ready = !filter_error_i;
                if (filter_error_i) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (clear_req_i) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DrainLd;
                end else if (any_valid) begin
                    if (look_valid_i) begin
                        // Advance past the blocked requester so others are not starved.
                        if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
                        ptr_d = win_next;
                    end else if (!filter_full_i && (filter_usage_i < MaxIf)) begin
                        req_ready[win] = 1'b1;
                        incr_valid     = 1'b1;
                        ptr_d          = win_next;
                    end
                end
            end

            ST_DRAIN: begin
                clear_busy = 1'b1;
                rel_ready  = !filter_error_i;
                if (filter_error_i) begin
                    error_d = 1'b1;
                    state_d = ST_ERROR;
                end else if (filter_empty_i && !rel_valid_i) begin
                    state_d = ST_CLEAR;
                end else if (drain_cnt_q == '0) begin
                    error_d  = 1'b1;
                    err_to_d = 1'b1;
                    state_d  = ST_CLEAR;
                end else begin
                    drain_cnt_d = drain_cnt_q - CntW'(1);
                end
            end

            ST_CLEAR: begin
                clear_busy   = 1'b1;
                filter_clear = 1'b1;
                clear_done   = 1'b1;
                state_d      = ST_RUN;
                // A drain timeout is never forgiven by a clear; only a recovered filter error is.
                if (error_q && !err_to_q && !filter_error_i) error_d = 1'b0;
            end

            ST_ERROR: begin
                if (clear_req_i) state_d = ST_CLEAR;
            end

            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            ptr_q       <= '0;
            stall_q     <= '0;
            error_q     <= 1'b0;
            err_to_q    <= 1'b0;
            drain_cnt_q <= '0;
            look_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            stall_q     <= stall_d;
            error_q     <= error_d;
            err_to_q    <= err_to_d;
            drain_cnt_q <= drain_cnt_d;
            look_data_q <= look_data_d;
        end
    end

    // Combinational outputs are forced low while reset is held so the whole port reads idle immediately.
    assign req_ready_o    = rst_i ? '0 : req_ready;
    assign incr_valid_o   = !rst_i && incr_valid;
    assign incr_data_o    = (!rst_i && incr_valid) ? win_data : '0;
    assign rel_ready_o    = !rst_i && rel_ready;
    assign decr_valid_o   = !rst_i && rel_ready && rel_valid_i;
    assign decr_data_o    = rst_i ? '0 : rel_data_i;
    assign look_data_o    = rst_i ? '0 : (any_valid ? win_data : look_data_q);
    assign filter_clear_o = !rst_i && filter_clear;
    assign clear_done_o   = !rst_i && clear_done;
    assign clear_busy_o   = !rst_i && clear_busy;
    assign error_o        = error_q;
    assign stall_cnt_o    = stall_q;

endmodule
